// File: rtl/base_ahold_gen.sv
// Packet framer: tags each beat with a hold flag so a downstream arbiter keeps its
// grant for the whole packet. Output goes through a two-entry skid buffer.
module base_ahold_gen #(
    parameter int width  = 8,
    parameter int lwidth = 4,
    parameter int lofs   = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              i_r,
    input  logic              i_v,
    input  logic [0:width-1]  i_d,
    input  logic              o_r,
    output logic              o_v,
    output logic              o_h,
    output logic [0:width-1]  o_d,
    output logic              dbg_body,
    output logic [lwidth-1:0] dbg_cnt
);

    // Handshake semantics: a beat moves on a port only in a cycle where valid and
    // ready are both high at the rising edge; valid never depends on ready.

    typedef enum logic {HDR, BODY} state_t;

    state_t              state, state_nx;
    logic [lwidth-1:0]   cnt, cnt_nx;
    logic [lwidth-1:0]   hdr_len;
    logic                tag_h;
    logic                in_xfer, out_xfer;

    logic                mv, mh, sv, sh;
    logic [0:width-1]    md, sd;

    // Length field is MSB first: i_d[lofs] is the most significant bit.
    assign hdr_len  = i_d[lofs +: lwidth];

    assign i_r      = ~sv & ~reset;
    assign in_xfer  = i_v & i_r;
    assign out_xfer = mv & o_r;

    assign o_v      = mv;
    assign o_h      = mh;
    assign o_d      = md;
    assign dbg_body = (state == BODY);
    assign dbg_cnt  = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HDR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tag_h    = 1'b0;
        case (state)
            HDR: begin
                tag_h = (hdr_len != '0);
                if (in_xfer && (hdr_len != '0)) begin
                    cnt_nx   = hdr_len;
                    state_nx = BODY;
                end
            end
            BODY: begin
                // cnt counts body beats still to come, including this one.
                tag_h = (cnt != lwidth'(1));
                if (in_xfer) begin
                    cnt_nx = cnt - lwidth'(1);
                    if (cnt == lwidth'(1))
                        state_nx = HDR;
                end
            end
            default: begin
                state_nx = HDR;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv <= 1'b0;
            mh <= 1'b0;
            md <= '0;
            sv <= 1'b0;
            sh <= 1'b0;
            sd <= '0;
        end else if (in_xfer) begin
            // in_xfer implies the skid is empty, so main takes the beat unless held.
            if (!mv || o_r) begin
                mv <= 1'b1;
                mh <= tag_h;
                md <= i_d;
            end else begin
                sv <= 1'b1;
                sh <= tag_h;
                sd <= i_d;
            end
        end else if (out_xfer) begin
            if (sv) begin
                mh <= sh;
                md <= sd;
                sv <= 1'b0;
            end else begin
                mv <= 1'b0;
                mh <= 1'b0;
            end
        end
    end

endmodule
